flag_reg_unit: RTL and testbench
================================

Name: flag_reg_unit

Overview:
Status/condition-code unit that consumes the Z/N/C/V flag outputs of the 16-bit ALU operation blocks. It holds them in an architectural flag register with a per-flag update mask, and saves/restores them through a small LIFO for interrupt/call entry and exit. It evaluates a 4-bit branch condition against the registered flags for the sequencer.

Parameters:
DEPTH, 4, number of entries in the flag save stack (power of two, >= 2)
CW, 3, width of stack occupancy counter; must satisfy 2**CW > DEPTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU result valid this cycle; apply masked flag update
alu_z  input  1  ALU zero flag
alu_n  input  1  ALU negative flag
alu_c  input  1  ALU carry flag
alu_v  input  1  ALU overflow flag
upd_mask  input  4  per-flag update enable {N,Z,C,V}; 0 = keep old value
wr_en  input  1  explicit flag register write (e.g. move-to-status)
wr_data  input  4  explicit write value {N,Z,C,V}
push  input  1  save current flags onto stack
pop  input  1  restore flags from stack top
err_clr  input  1  clear sticky error bits
cond  input  4  condition code to evaluate
cond_true  output  1  condition result (combinational from registered flags)
flags  output  4  registered flags {N,Z,C,V}
stk_count  output  CW  stack occupancy 0..DEPTH
stk_full  output  1  stk_count == DEPTH
stk_empty  output  1  stk_count == 0
ovf_err  output  1  sticky: push attempted while full
unf_err  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, rst_n low): flags=0000, stk_count=0, stk_empty=1, stk_full=0, ovf_err=0, unf_err=0. Stack contents are don't-care. cond_true follows cond from flags=0000 (EQ=0, NE=1, AL=1, NV=0, GE=1, etc.).
- Flags bit order is {N,Z,C,V} = flags[3:0] everywhere, including the stack and wr_data.
- Flag source priority per cycle, highest first:
  - valid pop: flags <= stack top.
  - wr_en: flags <= wr_data; upd_mask is ignored.
  - alu_valid: for each bit i, flags[i] <= upd_mask[i] ? alu flag : flags[i].
  - Otherwise flags hold.
- Latency: a new flag value is visible on flags and cond_true the cycle after the update edge. There is no bypass.
- Push (push=1, pop=0, not full): stack[count] <= flags as they were before this edge; count+1. A same-cycle wr_en/alu update still applies to flags.
- Pop (pop=1, push=0, not empty): flags <= stack[count-1]; count-1. Lower-priority sources are ignored this cycle.
- Push while full: stack and count unchanged; ovf_err <= 1; flag update proceeds normally.
- Pop while empty: count and stack unchanged; unf_err <= 1; the pop is not "valid", so wr_en/alu_valid apply.
- push and pop in the same cycle: both ignored (no stack change, no error); wr_en/alu_valid apply.
- err_clr: clears ovf_err/unf_err at the edge. A same-cycle new error wins (bit stays set).
- Condition table (cond -> cond_true):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - 10 GE N==V; 11 LT N!=V
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL 1; 15 NV 0
- Reset asserted mid-operation: immediate return to reset values, regardless of pending push/pop.

Test Plan:
- Reset, then alu_valid with Z=1,N=0,C=1,V=0, mask=1111 -> flags=0110 next cycle; cond=0 EQ gives 1, cond=8 HI gives 0, cond=9 LS gives 1.
- flags=0110, alu_valid N=1,Z=0,C=0,V=1, mask=1001 -> flags=1111; then wr_en wr_data=0001 together with alu_valid -> flags=0001 (wr_en wins).
- Set flags=1000, push; set flags=0100, push; pop -> flags=0100, count=1; pop -> flags=1000, count=0, stk_empty=1.
- Push DEPTH+1 times -> stk_full=1 after DEPTH pushes, ovf_err=1 on the extra push, count stays DEPTH; err_clr -> ovf_err=0.
- Pop on empty with alu_valid Z=1, mask=0100 -> unf_err=1, flags Z set, count 0. push+pop same cycle at count=2 -> count stays 2, no error.
- Sweep cond 0..15 for flags 1001 (N=V) and 1000 (N!=V) -> GE/LT/GT/LE/AL/NV match the table. Assert rst_n mid-push -> all outputs at reset values immediately.

Source files
------------

// File: rtl/flag_reg_unit.sv
// Architectural Z/N/C/V flag register with masked ALU update, explicit write,
// a small save/restore LIFO with sticky over/underflow errors, and branch-condition evaluation.
module flag_reg_unit #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic          alu_z,
  input  logic          alu_n,
  input  logic          alu_c,
  input  logic          alu_v,
  input  logic [3:0]    upd_mask,
  input  logic          wr_en,
  input  logic [3:0]    wr_data,
  input  logic          push,
  input  logic          pop,
  input  logic          err_clr,
  input  logic [3:0]    cond,
  output logic          cond_true,
  output logic [3:0]    flags,
  output logic [CW-1:0] stk_count,
  output logic          stk_full,
  output logic          stk_empty,
  output logic          ovf_err,
  output logic          unf_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [3:0]    flags_q, flags_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [3:0]    stk_q [DEPTH];

  logic          full, empty, push_only, pop_only, push_ok, pop_ok;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [3:0]    alu_flags;

  // Branch conditions over {N,Z,C,V}
  function automatic logic eval_cond(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'd0:    r = z;
      4'd1:    r = ~z;
      4'd2:    r = cy;
      4'd3:    r = ~cy;
      4'd4:    r = n;
      4'd5:    r = ~n;
      4'd6:    r = v;
      4'd7:    r = ~v;
      4'd8:    r = cy & ~z;
      4'd9:    r = ~cy | z;
      4'd10:   r = ~(n ^ v);
      4'd11:   r = n ^ v;
      4'd12:   r = ~z & ~(n ^ v);
      4'd13:   r = z | (n ^ v);
      4'd14:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    full      = (cnt_q == CNT_MAX);
    empty     = (cnt_q == '0);
    push_only = push & ~pop;
    pop_only  = pop & ~push;
    push_ok   = push_only & ~full;
    pop_ok    = pop_only & ~empty;
    wr_idx    = cnt_q[AW-1:0];
    // Wraps correctly when the stack is full (wr_idx == 0)
    rd_idx    = wr_idx - AW'(1);
    alu_flags = {alu_n, alu_z, alu_c, alu_v};

    flags_d = flags_q;
    if (pop_ok) begin
      flags_d = stk_q[rd_idx];
    end else if (wr_en) begin
      flags_d = wr_data;
    end else if (alu_valid) begin
      flags_d = (upd_mask & alu_flags) | (~upd_mask & flags_q);
    end

    cnt_d = cnt_q;
    if (push_ok) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop_ok) begin
      cnt_d = cnt_q - CW'(1);
    end

    // A new error in the same cycle as err_clr keeps the bit set
    ovf_d = (ovf_q & ~err_clr) | (push_only & full);
    unf_d = (unf_q & ~err_clr) | (pop_only & empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage carries no reset; its contents are only read below cnt_q
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stk_q[wr_idx] <= flags_q;
    end
  end

  assign flags     = flags_q;
  assign stk_count = cnt_q;
  assign stk_full  = full;
  assign stk_empty = empty;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;
  assign cond_true = eval_cond(flags_q, cond);

endmodule

// File: tb/tb_flag_reg_unit.sv
// Bench for flag_reg_unit: directed vector table, hand-written stack/condition
// sequences, then randomized traffic against a queue-based reference model.
module tb_flag_reg_unit;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, alu_z, alu_n, alu_c, alu_v;
  logic [3:0]    upd_mask;
  logic          wr_en;
  logic [3:0]    wr_data;
  logic          push, pop, err_clr;
  logic [3:0]    cond;
  logic          cond_true;
  logic [3:0]    flags;
  logic [CW-1:0] stk_count;
  logic          stk_full, stk_empty, ovf_err, unf_err;

  flag_reg_unit #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_z(alu_z), .alu_n(alu_n),
    .alu_c(alu_c), .alu_v(alu_v), .upd_mask(upd_mask), .wr_en(wr_en), .wr_data(wr_data),
    .push(push), .pop(pop), .err_clr(err_clr), .cond(cond), .cond_true(cond_true),
    .flags(flags), .stk_count(stk_count), .stk_full(stk_full), .stk_empty(stk_empty),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #20 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [3:0] m_flags;
  logic [3:0] m_stack[$];
  logic       m_ovf, m_unf;

  typedef struct {
    logic       av;
    logic [3:0] alu;   // {N,Z,C,V}
    logic [3:0] mask;
    logic       we;
    logic [3:0] wd;
    logic       ps, pp, ec;
    logic [3:0] e_flags;
    int         e_cnt;
    logic       e_ovf, e_unf;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
    bit n, z, cy, v, ge;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    ge = (n == v);
    case (c)
      0: return z;          1: return !z;
      2: return cy;         3: return !cy;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return cy && !z;   9: return !cy || z;
      10: return ge;        11: return !ge;
      12: return !z && ge;  13: return z || !ge;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Next-state from the current tb inputs, evaluated before the edge
  task automatic model_step();
    logic [3:0] old_flags, nf;
    bit pop_valid;
    old_flags = m_flags;
    pop_valid = 0;
    if (err_clr) begin
      m_ovf = 0;
      m_unf = 0;
    end
    nf = old_flags;
    if (push && !pop) begin
      if (m_stack.size() < DEPTH) m_stack.push_back(old_flags);
      else m_ovf = 1;
    end else if (pop && !push) begin
      if (m_stack.size() > 0) begin
        nf = m_stack.pop_back();
        pop_valid = 1;
      end else m_unf = 1;
    end
    if (!pop_valid) begin
      if (wr_en) nf = wr_data;
      else if (alu_valid)
        for (int b = 0; b < 4; b++)
          if (upd_mask[b]) nf[b] = {alu_n, alu_z, alu_c, alu_v}[b];
    end
    m_flags = nf;
  endtask

  task automatic check_all();
    logic [3:0] save_c;
    chk("flags", {4'b0, flags}, {4'b0, m_flags});
    chk("stk_count", {5'b0, stk_count}, 8'(m_stack.size()));
    chk("stk_full", {7'b0, stk_full}, {7'b0, m_stack.size() == DEPTH});
    chk("stk_empty", {7'b0, stk_empty}, {7'b0, m_stack.size() == 0});
    chk("ovf_err", {7'b0, ovf_err}, {7'b0, m_ovf});
    chk("unf_err", {7'b0, unf_err}, {7'b0, m_unf});
    save_c = cond;
    for (int c = 0; c < 16; c++) begin
      cond = 4'(c);
      #1;
      chk("cond_true", {7'b0, cond_true}, {7'b0, ref_cond(m_flags, cond)});
    end
    cond = save_c;
  endtask

  task automatic idle();
    alu_valid = 0; {alu_n, alu_z, alu_c, alu_v} = 4'b0; upd_mask = 4'b0;
    wr_en = 0; wr_data = 4'b0; push = 0; pop = 0; err_clr = 0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    idle();
    cond = 4'd0;
    rst_n = 0;
    model_reset();
    #5;
    check_all();
    @(posedge clk);
    #5;
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_fixed(input logic [3:0] f, input logic [15:0] table_bits);
    idle();
    wr_en = 1; wr_data = f;
    step();
    idle();
    for (int c = 0; c < 16; c++) begin
      cond = 4'(c);
      #1;
      chk("cond_sweep", {7'b0, cond_true}, {7'b0, table_bits[c]});
    end
  endtask

  initial begin
    logic [15:0] tbl;
    rst_n = 1;
    idle();
    cond = 0;
    #3;
    do_reset();
    chk("reset_flags", {4'b0, flags}, 8'h00);
    chk("reset_empty", {7'b0, stk_empty}, 8'h01);

    //            av  alu      mask     we wd       ps pp ec  e_flags  cnt ovf unf
    vecs[0]  = '{1, 4'b0110, 4'b1111, 0, 4'b0000, 0, 0, 0, 4'b0110, 0, 0, 0};
    vecs[1]  = '{1, 4'b1001, 4'b1001, 0, 4'b0000, 0, 0, 0, 4'b1111, 0, 0, 0};
    vecs[2]  = '{1, 4'b1110, 4'b1111, 1, 4'b0001, 0, 0, 0, 4'b0001, 0, 0, 0};
    vecs[3]  = '{0, 4'b0000, 4'b0000, 1, 4'b1000, 0, 0, 0, 4'b1000, 0, 0, 0};
    vecs[4]  = '{0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 0, 4'b1000, 1, 0, 0};
    vecs[5]  = '{0, 4'b0000, 4'b0000, 1, 4'b0100, 0, 0, 0, 4'b0100, 1, 0, 0};
    vecs[6]  = '{0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 0, 4'b0100, 2, 0, 0};
    vecs[7]  = '{1, 4'b1111, 4'b1111, 1, 4'b0011, 0, 1, 0, 4'b0100, 1, 0, 0};
    vecs[8]  = '{0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 0, 4'b1000, 0, 0, 0};
    vecs[9]  = '{1, 4'b0100, 4'b0100, 0, 4'b0000, 0, 1, 0, 4'b1100, 0, 0, 1};
    vecs[10] = '{0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 1, 4'b1100, 0, 0, 0};

    for (int i = 0; i < 11; i++) begin
      alu_valid = vecs[i].av;
      {alu_n, alu_z, alu_c, alu_v} = vecs[i].alu;
      upd_mask = vecs[i].mask; wr_en = vecs[i].we; wr_data = vecs[i].wd;
      push = vecs[i].ps; pop = vecs[i].pp; err_clr = vecs[i].ec;
      step();
      chk("vec_flags", {4'b0, flags}, {4'b0, vecs[i].e_flags});
      chk("vec_count", {5'b0, stk_count}, 8'(vecs[i].e_cnt));
      chk("vec_ovf", {7'b0, ovf_err}, {7'b0, vecs[i].e_ovf});
      chk("vec_unf", {7'b0, unf_err}, {7'b0, vecs[i].e_unf});
      if (i == 0) begin
        cond = 0; #1; chk("eq_0110", {7'b0, cond_true}, 8'h01);
        cond = 8; #1; chk("hi_0110", {7'b0, cond_true}, 8'h00);
        cond = 9; #1; chk("ls_0110", {7'b0, cond_true}, 8'h01);
      end
    end

    // Fill to full and overflow
    idle();
    for (int i = 0; i < DEPTH + 1; i++) begin
      idle(); push = 1; wr_en = 1; wr_data = 4'(i + 3);
      step();
    end
    chk("full_after_pushes", {7'b0, stk_full}, 8'h01);
    chk("ovf_set", {7'b0, ovf_err}, 8'h01);
    chk("count_at_depth", {5'b0, stk_count}, 8'(DEPTH));
    idle(); err_clr = 1; push = 1;
    step();
    chk("clr_vs_new_ovf", {7'b0, ovf_err}, 8'h01);
    idle(); err_clr = 1;
    step();
    chk("ovf_cleared", {7'b0, ovf_err}, 8'h00);
    idle(); pop = 1; step();
    idle(); pop = 1; step();
    idle(); push = 1; pop = 1; alu_valid = 1; alu_c = 1; upd_mask = 4'b0010;
    step();
    chk("pushpop_count", {5'b0, stk_count}, 8'h02);
    chk("pushpop_noerr", {6'b0, ovf_err, unf_err}, 8'h00);

    tbl = 16'h565A; sweep_fixed(4'b1001, tbl);
    tbl = 16'h6A9A; sweep_fixed(4'b1000, tbl);

    // Asynchronous reset in the middle of a push
    idle(); push = 1; cond = 4'd1;
    @(posedge clk);
    #7;
    rst_n = 0;
    model_reset();
    #1;
    chk("async_rst_flags", {4'b0, flags}, 8'h00);
    chk("async_rst_count", {5'b0, stk_count}, 8'h00);
    chk("async_rst_stat", {4'b0, stk_empty, stk_full, ovf_err, unf_err}, 8'h08);
    chk("async_rst_ne", {7'b0, cond_true}, 8'h01);
    idle();
    @(posedge clk);
    #5;
    rst_n = 1;
    @(posedge clk);
    #1;
    check_all();

    for (int i = 0; i < 800; i++) begin
      alu_valid = 1'($urandom_range(0, 1));
      {alu_n, alu_z, alu_c, alu_v} = 4'($urandom);
      upd_mask = 4'($urandom);
      wr_en = ($urandom_range(0, 4) == 0);
      wr_data = 4'($urandom);
      push = ($urandom_range(0, 2) == 0);
      pop = ($urandom_range(0, 2) == 0);
      err_clr = ($urandom_range(0, 7) == 0);
      cond = 4'($urandom);
      if (i == 400) do_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
